panel_entry: RTL and testbench
==============================

// Module: panel_entry
// PURPOSE
//  Front-panel command/entry stage between keyboard (debounced key levels) and display/cpu_control.
//  Edge-detects keys, shifts hex digits into an entry register and maintains the panel address.
//  Turns command keys into single write requests to cpu_control using a valid/ack handshake.
//  Drives the entry and address values shown by display.
// PARAMETERS
//  ADDR_W   16  panel address / entry register width (multiple of 4)
//  DATA_W   8   data byte width; taken from entry[DATA_W-1:0]
// PORTS
//  clk        in   1       system clock (25 MHz domain); single clock
//  rst        in   1       synchronous reset, active-high
//  key_hex    in   16      debounced hex key levels, bit n = key n
//  key_cmd    in   8       levels {toSP,toY,toX,toA,toPC,dec,load,storeinc} (bit0=storeinc)
//  entry      out  ADDR_W  entry shift register (display led_mem/led_data)
//  digits     out  3       digits entered since last clear, saturates at ADDR_W/4
//  addr       out  ADDR_W  current panel address (display led_pc)
//  req_valid  out  1       write request pending to cpu_control
//  req_kind   out  3       request type (codes below)
//  req_addr   out  ADDR_W  request address (MEM_WR addr, or new PC)
//  req_data   out  DATA_W  request data byte
//  req_ack    in   1       cpu_control accepts request; sampled only while req_valid=1
// BEHAVIOUR
//  Reset: entry=0, digits=0, addr=0, req_valid=0, req_kind=0, req_addr=0, req_data=0, state=IDLE;
//   key history regs = all ones, so keys held through reset never fire.
//  Press = level & ~prev (one-cycle pulse); prev updates every cycle in all states.
//  States: IDLE, WAIT_ACK. Presses in WAIT_ACK are discarded, not queued.
//  IDLE, per cycle; the highest-priority press this cycle is the only action taken:
//   priority storeinc > load > dec > toPC > toA > toX > toY > toSP > hex.
//  Hex: among pressed hex bits, the lowest index wins; entry <= {entry[ADDR_W-5:0], nibble};
//   digits <= min(digits+1, ADDR_W/4).
//  load: addr <= entry; entry <= 0; digits <= 0. No request.
//  dec: addr <= addr-1 (0x0000 wraps to 0xFFFF). Entry is unchanged. No request.
//  storeinc: req_kind=MEM_WR, req_addr=addr, req_data=entry[7:0]; -> WAIT_ACK.
//  toA/toX/toY/toSP: req_kind=REG_A/REG_X/REG_Y/REG_SP, req_data=entry[7:0],
//   req_addr=0; -> WAIT_ACK.
//  toPC: req_kind=REG_PC, req_addr=entry, req_data=0; -> WAIT_ACK.
//  req_valid rises on the clock edge after the press (latency 1).
//  While req_valid=1, req_* fields are held stable.
//  WAIT_ACK + req_ack: next edge req_valid=0, state=IDLE, entry=0, digits=0.
//   For MEM_WR only, also addr <= addr+1 (0xFFFF wraps to 0x0000).
//  req_ack while IDLE is ignored. A press in the same cycle as the ack is discarded.
//  The earliest new request is the cycle after the return to IDLE.
//  rst mid-request: req_valid drops at that edge; cpu_control must tolerate the abandoned request.
//  All arithmetic is modulo 2^ADDR_W; no other saturation except digits.
// STRUCTURE
//  Shared header panel_defs.vh holds the REQ_* kind localparams, used by panel_entry and cpu_control:
//   REQ_NONE=0, MEM_WR=1, REG_A=2, REG_X=3, REG_Y=4, REG_SP=5, REG_PC=6.
//  The header also holds the key_cmd bit indices.
//  One sub-module, key_edge #(W): prev register + press pulse. Instantiated for key_hex (W=16)
//   and for key_cmd (W=8).
//  Priority encoders and the FSM are inline in panel_entry.
// TESTING
//  1. Press hex 1,2,3,4,5 one at a time -> entry=0x2345, digits=4. Then load -> addr=0x2345,
//     entry=0.
//  2. entry=0x00AB, addr=0x1000, storeinc -> next cycle req_valid=1, MEM_WR, req_addr=0x1000,
//     req_data=0xAB. Hold ack low 5 cycles -> fields stable. Ack -> addr=0x1001, req_valid=0.
//  3. addr=0xFFFF, storeinc+ack -> addr=0x0000. Then dec -> addr=0xFFFF.
//  4. In one cycle press hex 3, hex 7 and toX -> REG_X request with the prior entry; no digit
//     shifted. Hex 3+7 alone -> nibble 3.
//  5. Press toPC during WAIT_ACK -> ignored, no second request after ack.
//     Key held across rst -> no press after reset.
//  6. Assert rst while req_valid=1 -> all outputs at reset values the following cycle.
//     Ack pulse while IDLE -> no state change.

Source files
------------

// File: rtl/panel_entry_pkg.sv
// Shared definitions for the front-panel entry stage and its consumers.
//   REQ_*  : request kind codes placed on req_kind toward cpu_control.
//   K_*    : bit positions of the command keys within key_cmd.
package panel_entry_pkg;

   localparam logic [2:0] REQ_NONE = 3'd0;
   localparam logic [2:0] MEM_WR   = 3'd1;
   localparam logic [2:0] REG_A    = 3'd2;
   localparam logic [2:0] REG_X    = 3'd3;
   localparam logic [2:0] REG_Y    = 3'd4;
   localparam logic [2:0] REG_SP   = 3'd5;
   localparam logic [2:0] REG_PC   = 3'd6;

   localparam int K_STOREINC = 0;
   localparam int K_LOAD     = 1;
   localparam int K_DEC      = 2;
   localparam int K_TOPC     = 3;
   localparam int K_TOA      = 4;
   localparam int K_TOX      = 5;
   localparam int K_TOY      = 6;
   localparam int K_TOSP     = 7;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_WAIT_ACK = 1'b1
   } panel_state_e;

endpackage

// File: rtl/panel_entry_key_edge.sv
// key_edge: rising-edge detector for a bank of debounced key levels.
//   clk   : system clock
//   rst   : synchronous active-high reset; history forced to all ones so
//           keys already held during reset never produce a press
//   level : debounced key levels
//   press : one-cycle pulse for each key that went 0 -> 1
module key_edge #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] level,
   output logic [W-1:0] press
);

   logic [W-1:0] prev_p0;

   always_ff @(posedge clk) begin
      if (rst) prev_p0 <= '1;
      else     prev_p0 <= level;
   end

   assign press = level & ~prev_p0;

endmodule

// File: rtl/panel_entry.sv
// panel_entry: front-panel command/entry stage between keyboard and
// display / cpu_control.
//   clk, rst   : 25 MHz clock, synchronous active-high reset
//   key_hex    : debounced hex key levels (bit n = key n)
//   key_cmd    : debounced command key levels (see K_* in the package)
//   entry      : hex entry shift register shown on the display
//   digits     : digits entered since last clear, saturating at ADDR_W/4
//   addr       : current panel address shown on the display
//   req_valid  : write request pending toward cpu_control
//   req_kind   : request type (REQ_* codes)
//   req_addr   : request address (MEM_WR target or new PC)
//   req_data   : request data byte
//   req_ack    : cpu_control accepts the request; only looked at while
//                req_valid is high
module panel_entry
   import panel_entry_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       key_hex,
   input  logic [7:0]        key_cmd,
   output logic [ADDR_W-1:0] entry,
   output logic [2:0]        digits,
   output logic [ADDR_W-1:0] addr,
   output logic              req_valid,
   output logic [2:0]        req_kind,
   output logic [ADDR_W-1:0] req_addr,
   output logic [DATA_W-1:0] req_data,
   input  logic              req_ack
);

   localparam logic [2:0]        DIG_MAX  = 3'(ADDR_W / 4);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   logic [15:0]  hex_press;
   logic [7:0]   cmd_press;
   panel_state_e state;

   // Lowest pressed hex key wins when several arrive in the same cycle.
   function automatic logic [3:0] low_hex(input logic [15:0] p);
      logic [3:0] n;
      n = '0;
      for (int i = 15; i >= 0; i--)
         if (p[i]) n = 4'(i);
      return n;
   endfunction

   function automatic logic [2:0] sat_digits(input logic [2:0] d);
      return (d >= DIG_MAX) ? DIG_MAX : d + 3'd1;
   endfunction

   key_edge #(.W(16)) u_hex_edge (
      .clk   (clk),
      .rst   (rst),
      .level (key_hex),
      .press (hex_press)
   );

   key_edge #(.W(8)) u_cmd_edge (
      .clk   (clk),
      .rst   (rst),
      .level (key_cmd),
      .press (cmd_press)
   );

   // Command FSM: one action per IDLE cycle, chosen by fixed priority;
   // presses seen while waiting for the ack are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         entry     <= '0;
         digits    <= '0;
         addr      <= '0;
         req_valid <= 1'b0;
         req_kind  <= REQ_NONE;
         req_addr  <= '0;
         req_data  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_press[K_STOREINC]) begin
                  req_valid <= 1'b1;
                  req_kind  <= MEM_WR;
                  req_addr  <= addr;
                  req_data  <= entry[DATA_W-1:0];
                  state     <= ST_WAIT_ACK;
               end else if (cmd_press[K_LOAD]) begin
                  addr   <= entry;
                  entry  <= '0;
                  digits <= '0;
               end else if (cmd_press[K_DEC]) begin
                  addr <= addr - ADDR_ONE;
               end else if (cmd_press[K_TOPC]) begin
                  req_valid <= 1'b1;
                  req_kind  <= REG_PC;
                  req_addr  <= entry;
                  req_data  <= '0;
                  state     <= ST_WAIT_ACK;
               end else if (|cmd_press[K_TOSP:K_TOA]) begin
                  req_valid <= 1'b1;
                  req_addr  <= '0;
                  req_data  <= entry[DATA_W-1:0];
                  state     <= ST_WAIT_ACK;
                  if (cmd_press[K_TOA])      req_kind <= REG_A;
                  else if (cmd_press[K_TOX]) req_kind <= REG_X;
                  else if (cmd_press[K_TOY]) req_kind <= REG_Y;
                  else                       req_kind <= REG_SP;
               end else if (|hex_press) begin
                  entry  <= {entry[ADDR_W-5:0], low_hex(hex_press)};
                  digits <= sat_digits(digits);
               end
            end
            ST_WAIT_ACK: begin
               // req_* stay frozen until the ack arrives.
               if (req_ack) begin
                  req_valid <= 1'b0;
                  entry     <= '0;
                  digits    <= '0;
                  state     <= ST_IDLE;
                  if (req_kind == MEM_WR) addr <= addr + ADDR_ONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_panel_entry.sv
module tb_panel_entry;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] key_hex = '0;
   logic [7:0]  key_cmd = '0;
   logic        req_ack = 1'b0;
   logic [15:0] entry, addr, req_addr;
   logic [2:0]  digits, req_kind;
   logic        req_valid;
   logic [7:0]  req_data;

   int n_checks = 0;
   int n_fail   = 0;

   panel_entry #(.ADDR_W(16), .DATA_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_hex   (key_hex),
      .key_cmd   (key_cmd),
      .entry     (entry),
      .digits    (digits),
      .addr      (addr),
      .req_valid (req_valid),
      .req_kind  (req_kind),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ack   (req_ack)
   );

   always #20 clk = ~clk;

   // Reference model: panel state described by the key rules directly.
   logic [15:0] m_entry, m_addr, m_raddr, m_prev_hex;
   logic [2:0]  m_digits, m_kind;
   logic        m_valid;
   logic [7:0]  m_rdata, m_prev_cmd;

   // Request kind produced by each command key; 0 = no request.
   int cmd_kind [8] = '{1, 0, 0, 6, 2, 3, 4, 5};

   task automatic m_step();
      logic [15:0] hp;
      logic [7:0]  cp;
      int          c, h;
      if (rst) begin
         m_entry = 0; m_digits = 0; m_addr = 0; m_valid = 0;
         m_kind = 0; m_raddr = 0; m_rdata = 0;
         m_prev_hex = '1; m_prev_cmd = '1;
         return;
      end
      hp = key_hex & ~m_prev_hex;
      cp = key_cmd & ~m_prev_cmd;
      m_prev_hex = key_hex;
      m_prev_cmd = key_cmd;
      if (m_valid) begin
         if (req_ack) begin
            m_valid = 0; m_entry = 0; m_digits = 0;
            if (m_kind == 1) m_addr = m_addr + 1;
         end
         return;
      end
      c = -1;
      for (int i = 0; i < 8; i++) if (c < 0 && cp[i]) c = i;
      h = -1;
      for (int i = 0; i < 16; i++) if (h < 0 && hp[i]) h = i;
      if (c == 1) begin
         m_addr = m_entry; m_entry = 0; m_digits = 0;
      end else if (c == 2) begin
         m_addr = m_addr - 1;
      end else if (c >= 0) begin
         m_valid = 1;
         m_kind  = 3'(cmd_kind[c]);
         m_raddr = (c == 0) ? m_addr : (c == 3) ? m_entry : 16'h0;
         m_rdata = (c == 3) ? 8'h00 : m_entry[7:0];
      end else if (h >= 0) begin
         m_entry  = m_entry * 16 + 16'(h);
         m_digits = (m_digits < 4) ? m_digits + 1 : 3'd4;
      end
   endtask

   task automatic tick();
      m_step();
      @(posedge clk);
      #1;
   endtask

   task automatic press_hex(input int k);
      key_hex = 16'(1) << k; tick();
      key_hex = '0;          tick();
   endtask

   task automatic press_cmd(input int k);
      key_cmd = 8'(1) << k; tick();
      key_cmd = '0;         tick();
   endtask

   task automatic ack_once();
      req_ack = 1'b1; tick();
      req_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; tick(); tick();
      n_checks++;
      if ({entry, digits, addr, req_valid, req_kind, req_addr, req_data} !== 63'd0) begin
         n_fail++;
         $display("FAIL reset_state got entry=%h dig=%0d addr=%h v=%b k=%0d ra=%h rd=%h want all 0",
                  entry, digits, addr, req_valid, req_kind, req_addr, req_data);
      end
      rst = 1'b0; tick();
   endtask

   task automatic test_hex_load();
      for (int k = 1; k <= 5; k++) press_hex(k);
      n_checks++;
      if (entry !== 16'h2345) begin n_fail++; $display("FAIL hex_entry got %h want 2345", entry); end
      n_checks++;
      if (digits !== 3'd4) begin n_fail++; $display("FAIL hex_digits_sat got %0d want 4", digits); end
      press_cmd(1);
      n_checks++;
      if (addr !== 16'h2345 || entry !== 16'h0 || digits !== 3'd0) begin
         n_fail++; $display("FAIL load got addr=%h entry=%h dig=%0d want 2345/0/0", addr, entry, digits);
      end
   endtask

   task automatic test_storeinc();
      press_hex(1); press_hex(0); press_hex(0); press_hex(0); press_cmd(1);
      press_hex(10); press_hex(11);
      key_cmd = 8'h01; tick();
      n_checks++;
      if ({req_valid, req_kind, req_addr, req_data} !== {1'b1, 3'd1, 16'h1000, 8'hAB}) begin
         n_fail++; $display("FAIL storeinc_latency got v=%b k=%0d a=%h d=%h want 1/1/1000/ab",
                            req_valid, req_kind, req_addr, req_data);
      end
      key_cmd = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if ({req_valid, req_kind, req_addr, req_data} !== {1'b1, 3'd1, 16'h1000, 8'hAB}) begin
            n_fail++; $display("FAIL storeinc_hold cyc %0d got v=%b k=%0d a=%h d=%h", i,
                               req_valid, req_kind, req_addr, req_data);
         end
      end
      ack_once();
      n_checks++;
      if (addr !== 16'h1001 || req_valid !== 1'b0 || entry !== 16'h0) begin
         n_fail++; $display("FAIL storeinc_ack got addr=%h v=%b entry=%h want 1001/0/0", addr, req_valid, entry);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 4; i++) press_hex(15);
      press_cmd(1);
      press_cmd(0);
      ack_once();
      n_checks++;
      if (addr !== 16'h0000) begin n_fail++; $display("FAIL inc_wrap got %h want 0000", addr); end
      press_cmd(2);
      n_checks++;
      if (addr !== 16'hFFFF) begin n_fail++; $display("FAIL dec_wrap got %h want ffff", addr); end
   endtask

   task automatic test_priority();
      press_hex(5); press_hex(6);
      key_hex = 16'h0088; key_cmd = 8'h20; tick();
      key_hex = '0; key_cmd = '0;
      n_checks++;
      if ({req_valid, req_kind, req_addr, req_data, entry} !== {1'b1, 3'd3, 16'h0, 8'h56, 16'h0056}) begin
         n_fail++; $display("FAIL cmd_over_hex got v=%b k=%0d a=%h d=%h entry=%h want 1/3/0/56/0056",
                            req_valid, req_kind, req_addr, req_data, entry);
      end
      tick(); ack_once();
      key_hex = 16'h0088; tick(); key_hex = '0; tick();
      n_checks++;
      if (entry !== 16'h0003 || digits !== 3'd1) begin
         n_fail++; $display("FAIL low_hex_wins got entry=%h dig=%0d want 0003/1", entry, digits);
      end
   endtask

   task automatic test_wait_ignore();
      press_hex(9);
      press_cmd(4);
      press_cmd(3);
      n_checks++;
      if (req_kind !== 3'd2 || req_data !== 8'h39) begin
         n_fail++; $display("FAIL wait_discard got k=%0d d=%h want 2/39", req_kind, req_data);
      end
      ack_once();
      for (int i = 0; i < 4; i++) tick();
      n_checks++;
      if (req_valid !== 1'b0) begin n_fail++; $display("FAIL no_queued_req got v=%b want 0", req_valid); end
      key_cmd = 8'h01; key_hex = 16'h0020;
      rst = 1'b1; tick(); rst = 1'b0;
      tick(); tick();
      n_checks++;
      if (req_valid !== 1'b0 || entry !== 16'h0) begin
         n_fail++; $display("FAIL held_through_reset got v=%b entry=%h want 0/0", req_valid, entry);
      end
      key_cmd = '0; key_hex = '0; tick();
   endtask

   task automatic test_rst_mid();
      press_hex(4);
      key_cmd = 8'h08; tick(); key_cmd = '0;
      rst = 1'b1; tick(); rst = 1'b0;
      n_checks++;
      if ({entry, digits, addr, req_valid, req_kind, req_addr, req_data} !== 63'd0) begin
         n_fail++; $display("FAIL rst_mid_req got entry=%h v=%b k=%0d a=%h want all 0",
                            entry, req_valid, req_kind, req_addr);
      end
      tick();
      press_hex(4);
      ack_once(); tick();
      n_checks++;
      if (entry !== 16'h0004 || digits !== 3'd1 || req_valid !== 1'b0) begin
         n_fail++; $display("FAIL idle_ack got entry=%h dig=%0d v=%b want 0004/1/0", entry, digits, req_valid);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         key_hex = ($urandom_range(0, 2) == 0) ? (16'(1) << $urandom_range(0, 15)) : 16'h0;
         if ($urandom_range(0, 5) == 0) key_hex = key_hex | (16'(1) << $urandom_range(0, 15));
         key_cmd = ($urandom_range(0, 6) == 0) ? (8'(1) << $urandom_range(0, 7)) : 8'h0;
         req_ack = ($urandom_range(0, 2) == 0);
         rst     = ($urandom_range(0, 149) == 0);
         tick();
         n_checks++;
         if ({entry, digits, addr, req_valid, req_kind, req_addr, req_data} !==
             {m_entry, m_digits, m_addr, m_valid, m_kind, m_raddr, m_rdata}) begin
            n_fail++;
            $display("FAIL random cyc %0d got e=%h d=%0d a=%h v=%b k=%0d ra=%h rd=%h want e=%h d=%0d a=%h v=%b k=%0d ra=%h rd=%h",
                     i, entry, digits, addr, req_valid, req_kind, req_addr, req_data,
                     m_entry, m_digits, m_addr, m_valid, m_kind, m_raddr, m_rdata);
         end
      end
      key_hex = '0; key_cmd = '0; req_ack = 1'b0; rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_hex_load();
      test_storeinc();
      test_wrap();
      test_priority();
      test_wait_ignore();
      test_rst_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
